alu_req_arbiter: RTL
====================

Name: alu_req_arbiter

Overview:
- Two-requester front-end controller for the shared combinational ALU (AND / OR / ADD, parameterised width, carry output).
- Arbitrates round-robin between two operation requesters and sequences one operation at a time through the ALU.
- Holds each result, tagged with the requester ID, until the consumer accepts it.
- Sits between the requesting blocks and a single ALU instance driven through its alu_* ports.

Parameters:
- WIDTH, 4, operand/result width; passed to the ALU's width parameter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  operand A, signed two's complement
- req0_b  in  WIDTH  operand B, signed two's complement
- req0_sel  in  2  opcode: 00 AND, 01 OR, 10 ADD, 11 illegal
- req1_valid / req1_ready / req1_a / req1_b / req1_sel  as requester 0
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_sel  out  2  ALU select
- alu_out  in  WIDTH  ALU result, combinational from alu_*
- alu_carry  in  1  ALU carry
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_out  out  WIDTH  captured result
- resp_carry  out  1  captured carry; 0 unless opcode was ADD
- resp_id  out  1  requester that issued the operation
- resp_err  out  1  opcode was illegal (11)

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - reqN_ready is asserted combinationally only for the granted requester, and only when that requester's valid is high.
  - Grant rules: only one valid, grant it; both valid, grant ~last_grant; neither valid, no ready.
  - On a handshake (reqN_valid & reqN_ready): latch a, b, sel and id; update last_grant to N; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Legal opcode: alu_a, alu_b, alu_sel driven from the latched registers.
  - End of cycle captures: resp_out <= alu_out; resp_carry <= alu_carry when sel==10, else 0; resp_err <= 0.
  - Illegal opcode: the ALU is not driven; capture resp_out=0, resp_carry=0, resp_err=1.
  - Always go to RESP.
- RESP:
  - resp_valid=1. resp_out, resp_carry, resp_id and resp_err are stable until the handshake.
  - On resp_ready: return to IDLE; resp_valid drops the next cycle.
- Latency: request handshake in cycle N, then ISSUE in N+1, then resp_valid in N+2. Throughput is at best one operation per 3 cycles with resp_ready held high.
- The ALU is driven with alu_a=0, alu_b=0, alu_sel=00 in every state except ISSUE.
- Both reqN_ready are 0 outside IDLE. No request is dropped: an unaccepted requester must hold valid and operands.
- Arithmetic:
  - ADD result is WIDTH bits; resp_carry is the ALU carry-out (unsigned).
  - Signed overflow is not flagged.
  - Subtraction is ADD with B supplied as its two's-complement negative by the requester.
- resp_ready high while resp_valid is low has no effect.
- Reset mid-operation: any state returns to IDLE immediately. A captured result is discarded; resp_valid and all outputs go 0 asynchronously.
- A requester deasserting valid in the same cycle that ready rises counts as no handshake (ready is gated by valid).

Decomposition:
- Shared package alu_pkg: opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_ILL=2'b11; FSM state encoding.
- Optional sub-module rr_arb2: two-input round-robin grant with last_grant register.
- The ALU itself stays outside this block.

Test Plan:
- Single ADD: req0 a=0011 b=0111 sel=10 -> resp_out=1010, resp_carry=0, resp_id=0, resp_valid exactly 2 cycles after the handshake.
- ADD with carry: req1 a=1011 b=0110 -> resp_out=0001, resp_carry=1, resp_id=1. Then a=1111 b=0100 -> resp_out=0011, resp_carry=1.
- Logic ops with carry masking: AND a=0011 b=0111 -> 0011, carry=0. OR a=1011 b=0110 -> 1111, carry=0, even if the ALU carry pin is forced to 1.
- Contention: both valid continuously from reset, resp_ready=1 -> grants alternate 0,1,0,1. resp_id sequence is 0,1,0,1 and neither requester is starved.
- Backpressure and illegal opcode:
  - resp_ready=0 for 5 cycles -> resp_* stable, both reqN_ready=0.
  - req0 sel=11 -> resp_err=1, resp_out=0000, alu_sel stays 00.
- Reset mid-op: assert rst_n=0 during ISSUE -> all outputs 0 without waiting for a clock edge. After release, requester 0 wins a tie.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode constants and FSM encoding shared by the ALU request arbiter.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [1:0] sel);
        return sel != OP_ILL;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; a tie goes to the requester not granted last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    last_grant <= 1'b1;
        else if (take) last_grant <= gnt[1];
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Front end for a shared combinational ALU: arbitrates two requesters,
// issues one operation at a time and holds the tagged result until accepted.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_out,
    output logic             resp_carry,
    output logic             resp_id,
    output logic             resp_err
);

    state_t           state;
    logic [WIDTH-1:0] op_a, op_b;
    logic [1:0]       op_sel;
    logic             op_id;
    logic [1:0]       arb_req, gnt;
    logic             take;

    // Requests are only visible to the arbiter while idle, so ready is 0 elsewhere.
    assign arb_req    = {req1_valid, req0_valid} & {2{state == ST_IDLE}};
    assign take       = |gnt;
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (arb_req),
        .take  (take),
        .gnt   (gnt)
    );

    // The ALU sees zeros except while a legal operation is in flight.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = OP_AND;
        if (state == ST_ISSUE && op_legal(op_sel)) begin
            alu_a   = op_a;
            alu_b   = op_b;
            alu_sel = op_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= OP_AND;
            op_id      <= 1'b0;
            resp_valid <= 1'b0;
            resp_out   <= '0;
            resp_carry <= 1'b0;
            resp_id    <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        op_a   <= gnt[1] ? req1_a   : req0_a;
                        op_b   <= gnt[1] ? req1_b   : req0_b;
                        op_sel <= gnt[1] ? req1_sel : req0_sel;
                        op_id  <= gnt[1];
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    resp_out   <= op_legal(op_sel) ? alu_out : '0;
                    resp_carry <= (op_sel == OP_ADD) && alu_carry;
                    resp_err   <= !op_legal(op_sel);
                    resp_id    <= op_id;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
